rs_syndrome_calc: RTL and testbench

- Downstream stage of the RS(15,9) GF(16) encoder; first stage of the decode path.
- Accepts one packed 60-bit codeword and computes the 6 syndromes S1..S6, S_j = C(alpha^j), serially using Horner's rule at one symbol per clock.
- Reports the packed syndromes with a one-cycle valid pulse; all-zero syndromes mean the word is error-free.
- Feeds the error-locator (key-equation) stage.

---
 rtl/rs_pkg.sv | 26 ++
 rtl/gf16_mul.sv | 29 ++
 rtl/rs_syndrome_calc.sv | 123 ++++++++++++
 tb/tb_rs_syndrome_calc.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared constants, types and GF(16) tables for the RS(15,9) decode path
package rs_pkg;

    localparam int N_SYM    = 15;
    localparam int K_SYM    = 9;
    localparam int SYM_W    = 4;
    localparam int NUM_SYND = N_SYM - K_SYM;
    localparam int CNT_W    = 4;

    typedef logic [SYM_W-1:0] gf_sym_t;

    // x^4 + x + 1
    localparam logic [SYM_W:0] PRIM_POLY = 5'b10011;

    // ALPHA_POW[k] = alpha^k with alpha = 0010
    localparam gf_sym_t ALPHA_POW [N_SYM] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
        4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
    };

    typedef enum logic {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

endpackage

// File: rtl/gf16_mul.sv
// rtl/gf16_mul.sv - combinational GF(2^4) multiplier, polynomial product reduced mod x^4+x+1
module gf16_mul
    import rs_pkg::*;
(
    input  logic [SYM_W-1:0] i_a,
    input  logic [SYM_W-1:0] i_b,
    output logic [SYM_W-1:0] o_p
);

    logic [2*SYM_W-2:0] w_prod;

    // Carry-less product, then fold the high terms back using the field polynomial
    always_comb begin
        w_prod = '0;
        for (int i = 0; i < SYM_W; i++) begin
            if (i_b[i]) begin
                w_prod = w_prod ^ ({{(SYM_W-1){1'b0}}, i_a} << i);
            end
        end
        for (int k = 2*SYM_W-2; k >= SYM_W; k--) begin
            if (w_prod[k]) begin
                w_prod = w_prod ^ ({{(SYM_W-2){1'b0}}, PRIM_POLY} << (k - SYM_W));
            end
        end
    end

    assign o_p = w_prod[SYM_W-1:0];

endmodule

// File: rtl/rs_syndrome_calc.sv
// rtl/rs_syndrome_calc.sv - serial Horner syndrome calculator for RS(15,9); optional RS_SYND_ERR_FLAG_EN adds error flag and counter
module rs_syndrome_calc
    import rs_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SYM*SYM_W-1:0] codeWordVector,
    input  logic                   start,
    output logic                   busy,
    output logic                   synd_valid,
    output logic [NUM_SYND*SYM_W-1:0] syndromes
`ifdef RS_SYND_ERR_FLAG_EN
    ,
    output logic                   synd_nonzero,
    output logic [7:0]             err_word_count
`endif
);

    state_t                      r_state;
    logic [N_SYM*SYM_W-1:0]      r_cw;
    logic [CNT_W-1:0]            r_cnt;
    gf_sym_t                     r_acc [NUM_SYND];
    logic                        r_busy;
    logic                        r_valid;
    logic [NUM_SYND*SYM_W-1:0]   r_synd;

    gf_sym_t                     w_syms [N_SYM];
    gf_sym_t                     w_sym;
    gf_sym_t                     w_mul  [NUM_SYND];
    gf_sym_t                     w_next [NUM_SYND];
    logic [NUM_SYND*SYM_W-1:0]   w_next_flat;
    logic                        w_done;

    for (genvar i = 0; i < N_SYM; i++) begin : g_split
        assign w_syms[i] = r_cw[i*SYM_W +: SYM_W];
    end

    // Symbols are consumed highest degree first so Horner ends on the constant term
    assign w_sym  = w_syms[r_cnt];
    assign w_done = (r_state == COMPUTE) && (r_cnt == '0);

    for (genvar j = 0; j < NUM_SYND; j++) begin : g_horner
        gf16_mul u_mul (
            .i_a (r_acc[j]),
            .i_b (ALPHA_POW[j+1]),
            .o_p (w_mul[j])
        );
        assign w_next[j] = w_mul[j] ^ w_sym;
        assign w_next_flat[j*SYM_W +: SYM_W] = w_next[j];
    end

    // Control FSM plus accumulators; the result register is loaded on the last symbol step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cw    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_synd  <= '0;
            for (int j = 0; j < NUM_SYND; j++) begin
                r_acc[j] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cw    <= codeWordVector;
                        r_cnt   <= CNT_W'(N_SYM - 1);
                        r_busy  <= 1'b1;
                        r_state <= COMPUTE;
                        for (int j = 0; j < NUM_SYND; j++) begin
                            r_acc[j] <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    for (int j = 0; j < NUM_SYND; j++) begin
                        r_acc[j] <= w_next[j];
                    end
                    if (r_cnt == '0) begin
                        r_synd  <= w_next_flat;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign synd_valid = r_valid;
    assign syndromes  = r_synd;

`ifdef RS_SYND_ERR_FLAG_EN
    logic       r_nonzero;
    logic [7:0] r_err_cnt;

    // Nonzero flag tracks the syndrome register; counter saturates rather than wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nonzero <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_done) begin
            r_nonzero <= |w_next_flat;
            if ((|w_next_flat) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign synd_nonzero   = r_nonzero;
    assign err_word_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// tb/tb_rs_syndrome_calc.sv - self-checking bench for rs_syndrome_calc
module tb_rs_syndrome_calc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [59:0] codeWordVector = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        synd_valid;
    logic [23:0] syndromes;
`ifdef RS_SYND_ERR_FLAG_EN
    logic        synd_nonzero;
    logic [7:0]  err_word_count;
`endif

    rs_syndrome_calc dut (
        .clk            (clk),
        .rst            (rst),
        .codeWordVector (codeWordVector),
        .start          (start),
        .busy           (busy),
        .synd_valid     (synd_valid),
        .syndromes      (syndromes)
`ifdef RS_SYND_ERR_FLAG_EN
        ,
        .synd_nonzero   (synd_nonzero),
        .err_word_count (err_word_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // GF(16) via exp/log tables
    logic [3:0] gexp [15];
    int         glog [16];
    logic [3:0] gpoly [7];

    function automatic logic [3:0] fmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    // Direct evaluation S_j = sum c_i * alpha^(i*j)
    function automatic logic [23:0] model_synd(input logic [59:0] cw);
        logic [23:0] r;
        logic [3:0]  s;
        r = '0;
        for (int j = 1; j <= 6; j++) begin
            s = 4'h0;
            for (int i = 0; i < 15; i++) s = s ^ fmul(cw[4*i +: 4], gexp[(i*j) % 15]);
            r[4*(j-1) +: 4] = s;
        end
        return r;
    endfunction

    // Systematic encoder: parity = M(x)*x^6 mod g(x)
    function automatic logic [59:0] encode(input logic [35:0] msg);
        logic [59:0] cw;
        logic [3:0]  p [6];
        logic [3:0]  fb;
        for (int i = 0; i < 6; i++) p[i] = 4'h0;
        cw = '0;
        for (int k = 8; k >= 0; k--) begin
            fb = msg[4*k +: 4] ^ p[5];
            for (int i = 5; i >= 1; i--) p[i] = p[i-1] ^ fmul(fb, gpoly[i]);
            p[0] = fmul(fb, gpoly[0]);
            cw[4*(6+k) +: 4] = msg[4*k +: 4];
        end
        for (int i = 0; i < 6; i++) cw[4*i +: 4] = p[i];
        return cw;
    endfunction

    // Transaction-level reference: a started word reports 15 edges after its load edge
    logic        m_busy = 1'b0;
    logic        m_valid = 1'b0;
    logic [23:0] m_synd = '0;
    logic [23:0] m_pend = '0;
    int          m_left = 0;
    logic        m_nz = 1'b0;
    int          m_errs = 0;
    logic        cmp_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_valid = 1'b0; m_synd = '0; m_left = 0; m_nz = 1'b0; m_errs = 0;
        end else begin
            m_valid = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    m_busy  = 1'b0;
                    m_synd  = m_pend;
                    m_nz    = (m_pend != 0);
                    if (m_nz && m_errs < 255) m_errs++;
                end
            end else if (start) begin
                m_pend = model_synd(codeWordVector);
                m_left = 15;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("synd_valid", 32'(synd_valid), 32'(m_valid));
            chk("syndromes", 32'(syndromes), 32'(m_synd));
`ifdef RS_SYND_ERR_FLAG_EN
            chk("synd_nonzero", 32'(synd_nonzero), 32'(m_nz));
            chk("err_word_count", 32'(err_word_count), 32'(m_errs));
`endif
        end
    end

    // Single start pulse; returns the result, start-to-valid latency and busy-high cycle count
    task automatic run_word(input logic [59:0] cw, output logic [23:0] res, output int lat, output int nbusy);
        @(negedge clk);
        codeWordVector = cw;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        nbusy = busy ? 1 : 0;
        while (!synd_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
        end
        if (!synd_valid) chk("valid_timeout", 32'(lat), 32'd16);
        res = syndromes;
    endtask

    logic [59:0] cw_zero, cw_s0, cw_s1, cw_enc;
    logic [23:0] res;
    int          lat, nbusy, nvalid;
`ifdef RS_SYND_ERR_FLAG_EN
    logic [7:0]  cnt_before;
`endif

    initial begin
        // field tables and generator polynomial
        gexp[0] = 4'h1;
        for (int k = 1; k < 15; k++)
            gexp[k] = gexp[k-1][3] ? ((gexp[k-1] << 1) ^ 4'h3) : (gexp[k-1] << 1);
        glog[0] = 0;
        for (int k = 0; k < 15; k++) glog[gexp[k]] = k;
        for (int i = 0; i < 7; i++) gpoly[i] = 4'h0;
        gpoly[0] = 4'h1;
        for (int j = 1; j <= 6; j++) begin
            for (int i = 6; i >= 1; i--) gpoly[i] = gpoly[i-1] ^ fmul(gpoly[i], gexp[j]);
            gpoly[0] = fmul(gpoly[0], gexp[j]);
        end

        cw_zero = '0;
        cw_s0 = '0; cw_s0[3:0] = 4'h1;
        cw_s1 = '0; cw_s1[7:4] = 4'h1;
        cw_enc = encode(36'h123456789);

        chk("model_s1_literal", 32'(model_synd(cw_s1)), 32'h00C63842);
        chk("model_enc_zero", 32'(model_synd(cw_enc)), 32'h0);
        chk("enc_msg_field", 32'(cw_enc[59:24]), 32'h23456789);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(synd_valid), 32'd0);
        chk("rst_synd", 32'(syndromes), 32'd0);
        cmp_en = 1'b1;

        run_word(cw_zero, res, lat, nbusy);
        chk("zero_synd", 32'(res), 32'h0);
        chk("zero_latency", 32'(lat), 32'd16);
        chk("zero_busy_cycles", 32'(nbusy), 32'd15);

`ifdef RS_SYND_ERR_FLAG_EN
        cnt_before = err_word_count;
`endif
        run_word(cw_enc, res, lat, nbusy);
        chk("enc_synd", 32'(res), 32'h0);
`ifdef RS_SYND_ERR_FLAG_EN
        chk("enc_nonzero", 32'(synd_nonzero), 32'd0);
        chk("enc_count", 32'(err_word_count), 32'(cnt_before));
`endif

        run_word(cw_s0, res, lat, nbusy);
        chk("sym0_synd", 32'(res), 32'h111111);
        run_word(cw_s1, res, lat, nbusy);
        chk("sym1_synd", 32'(res), 32'hC63842);
`ifdef RS_SYND_ERR_FLAG_EN
        chk("sym1_nonzero", 32'(synd_nonzero), 32'd1);
        chk("err_count_two", 32'(err_word_count), 32'd2);
`endif

        // start held high with a codeword that changes every cycle
        @(negedge clk);
        start = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 48; k++) begin
            codeWordVector = k[0] ? cw_s1 : cw_s0;
            @(negedge clk);
            if (synd_valid) nvalid++;
        end
        start = 1'b0;
        chk("stream_valid_count", 32'(nvalid), 32'd3);
        repeat (20) @(negedge clk);

        // reset in the 8th compute cycle
        codeWordVector = cw_s1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_synd", 32'(syndromes), 32'd0);
        nvalid = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (synd_valid) nvalid++;
        end
        chk("abort_no_valid", 32'(nvalid), 32'd0);
        run_word(cw_s1, res, lat, nbusy);
        chk("after_abort_synd", 32'(res), 32'hC63842);
        chk("after_abort_latency", 32'(lat), 32'd16);

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
